// File: rtl/serial_mag_compare_ctrl_if.sv
// Start/done handshake bundle for the serial magnitude comparator.
// The master drives the request and operands; the slave returns status and result.
interface serial_mag_compare_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 3
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic             less;
  logic             equal;
  logic             greater;
  logic [CNTW-1:0]  steps;

  modport master (
    output start, a, b,
    input  ready, done, less, equal, greater, steps
  );

  modport slave (
    input  start, a, b,
    output ready, done, less, equal, greater, steps
  );
endinterface

// File: rtl/serial_mag_compare_ctrl.sv
// Bit-serial unsigned magnitude comparator: walks the operands MSB-first through one
// shared 1-bit compare and stops at the first differing bit.
module serial_mag_compare_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_mag_compare_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNTW-1:0]  idx_q, idx_d;
  logic [CNTW-1:0]  steps_q, steps_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             less_q, less_d;
  logic             equal_q, equal_d;
  logic             greater_q, greater_d;

  logic             abit_s;
  logic             bbit_s;

  // A mask-and-reduce picks the current bit without an index narrower than idx_q.
  assign abit_s = |(a_q & (WIDTH'(1) << idx_q));
  assign bbit_s = |(b_q & (WIDTH'(1) << idx_q));

  // Next-state and next-output logic for the IDLE/COMPARE/DONE sequence.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    steps_d   = steps_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    less_d    = less_q;
    equal_d   = equal_q;
    greater_d = greater_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d       = bus.a;
          b_d       = bus.b;
          idx_d     = CNTW'(WIDTH - 1);
          steps_d   = {CNTW{1'b0}};
          less_d    = 1'b0;
          equal_d   = 1'b0;
          greater_d = 1'b0;
          ready_d   = 1'b0;
          state_d   = S_COMPARE;
        end else begin
          ready_d   = 1'b1;
        end
      end
      S_COMPARE: begin
        ready_d = 1'b0;
        steps_d = steps_q + CNTW'(1);
        if (!abit_s && bbit_s) begin
          less_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (abit_s && !bbit_s) begin
          greater_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else if (idx_q == CNTW'(0)) begin
          equal_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - CNTW'(1);
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand and output registers; reset discards any comparison in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      idx_q     <= {CNTW{1'b0}};
      steps_q   <= {CNTW{1'b0}};
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      steps_q   <= steps_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      less_q    <= less_d;
      equal_q   <= equal_d;
      greater_q <= greater_d;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.less    = less_q;
  assign bus.equal   = equal_q;
  assign bus.greater = greater_q;
  assign bus.steps   = steps_q;

endmodule
